ex_stage_mc: RTL and testbench

//  Parametrised execute stage between decode and memory stages: pipeline register, ALU, store byte-lane alignment,

---
 rtl/ex_stage_mc.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage between decode and memory.
// Holds one instruction in a pipeline register and computes its result with the ALU.
// Store byte strobes and lane-replicated write data go straight to the data RAM.
// Forwarding information is exported for the decode stage.
// Optional feature macro: EX_STAGE_DIV_EN.
//   Defined:   ops 15-18 run on an iterative restoring divider, one quotient bit per cycle.
//   Undefined: ops 15-18 finish in one cycle and return 0.
// LUI returns src2 unchanged, because decode has already positioned the immediate.
module ex_stage_mc #(
    parameter int XLEN   = 32,
    parameter int DEST_W = 5,
    parameter int OP_W   = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_allow,
    input  logic [OP_W-1:0]               in_op,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [XLEN-1:0]               in_src1,
    input  logic [XLEN-1:0]               in_src2,
    input  logic [XLEN-1:0]               in_rkd,
    input  logic [DEST_W-1:0]             in_dest,
    input  logic                          in_gr_we,
    input  logic                          in_mem_rd,
    input  logic                          in_mem_wr,
    input  logic [1:0]                    in_mem_size,
    input  logic                          in_ld_signed,
    output logic                          out_valid,
    input  logic                          out_allow,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_result,
    output logic [DEST_W-1:0]             out_dest,
    output logic                          out_gr_we,
    output logic                          out_mem_rd,
    output logic [$clog2(XLEN/8)+2:0]     out_ld_info,
    output logic                          dsram_en,
    output logic [XLEN/8-1:0]             dsram_we,
    output logic [XLEN-1:0]               dsram_addr,
    output logic [XLEN-1:0]               dsram_wdata,
    output logic [DEST_W-1:0]             fwd_dest,
    output logic [XLEN-1:0]               fwd_result,
    output logic                          fwd_is_load
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_MULH  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_MULHU = OP_W'(14);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_MOD   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_MODU  = OP_W'(18);

    logic                valid_reg;
    logic [OP_W-1:0]     op_reg;
    logic [XLEN-1:0]     pc_reg, src1_reg, src2_reg, rkd_reg;
    logic [DEST_W-1:0]   dest_reg;
    logic                gr_we_reg, mem_rd_reg, mem_wr_reg, ld_signed_reg;
    logic [1:0]          size_reg;

    logic                ready_go;
    logic [XLEN-1:0]     div_result;
    logic [XLEN-1:0]     alu_result;

    // Pipeline register: valid follows decode whenever the stage can accept; flush empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            op_reg        <= '0;
            pc_reg        <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            rkd_reg       <= '0;
            dest_reg      <= '0;
            gr_we_reg     <= 1'b0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            size_reg      <= 2'd0;
            ld_signed_reg <= 1'b0;
        end else begin
            if (flush) begin
                valid_reg <= 1'b0;
            end else if (in_allow) begin
                valid_reg <= in_valid;
            end
            if (in_allow && in_valid && !flush) begin
                op_reg        <= in_op;
                pc_reg        <= in_pc;
                src1_reg      <= in_src1;
                src2_reg      <= in_src2;
                rkd_reg       <= in_rkd;
                dest_reg      <= in_dest;
                gr_we_reg     <= in_gr_we;
                mem_rd_reg    <= in_mem_rd;
                mem_wr_reg    <= in_mem_wr;
                size_reg      <= in_mem_size;
                ld_signed_reg <= in_ld_signed;
            end
        end
    end

    // One 2XLEN multiplier serves all three multiply ops; only the operand extension differs.
    logic [SH_W-1:0]     shamt;
    logic [2*XLEN-1:0]   mul_a, mul_b, mul_full;
    logic                mul_unsigned;

    assign shamt        = src2_reg[SH_W-1:0];
    assign mul_unsigned = (op_reg == OP_MULHU);
    assign mul_a        = mul_unsigned ? {{XLEN{1'b0}}, src1_reg} : {{XLEN{src1_reg[XLEN-1]}}, src1_reg};
    assign mul_b        = mul_unsigned ? {{XLEN{1'b0}}, src2_reg} : {{XLEN{src2_reg[XLEN-1]}}, src2_reg};
    assign mul_full     = mul_a * mul_b;

    // Single-cycle ALU; the divide ops read the divider's held result.
    always_comb begin
        alu_result = '0;
        case (op_reg)
            OP_ADD:   alu_result = src1_reg + src2_reg;
            OP_SUB:   alu_result = src1_reg - src2_reg;
            OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(src1_reg) < $signed(src2_reg))};
            OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (src1_reg < src2_reg)};
            OP_AND:   alu_result = src1_reg & src2_reg;
            OP_OR:    alu_result = src1_reg | src2_reg;
            OP_XOR:   alu_result = src1_reg ^ src2_reg;
            OP_NOR:   alu_result = ~(src1_reg | src2_reg);
            OP_SLL:   alu_result = src1_reg << shamt;
            OP_SRL:   alu_result = src1_reg >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(src1_reg) >>> shamt);
            OP_LUI:   alu_result = src2_reg;
            OP_MUL:   alu_result = mul_full[XLEN-1:0];
            OP_MULH,
            OP_MULHU: alu_result = mul_full[2*XLEN-1:XLEN];
            OP_DIV, OP_MOD,
            OP_DIVU, OP_MODU: alu_result = div_result;
            default:  alu_result = '0;
        endcase
    end

`ifdef EX_STAGE_DIV_EN
    localparam int CNT_W = $clog2(XLEN);

    // SIGN is the sign/special-case fix-up cycle that follows the last quotient bit.
    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_SIGN, D_DONE} div_state_e;
    div_state_e state_reg, state_next;

    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   rem_reg, quo_reg, dvs_reg, res_reg;
    logic              is_div_op, is_signed_div, is_rem_op, src1_neg, src2_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic              ge;
    logic [XLEN-1:0]   step_rem, step_quo, q_fix, r_fix, div_final;

    assign is_div_op     = (op_reg == OP_DIV) || (op_reg == OP_MOD) || (op_reg == OP_DIVU) || (op_reg == OP_MODU);
    assign is_signed_div = (op_reg == OP_DIV) || (op_reg == OP_MOD);
    assign is_rem_op     = (op_reg == OP_MOD) || (op_reg == OP_MODU);
    assign src1_neg      = is_signed_div && src1_reg[XLEN-1];
    assign src2_neg      = is_signed_div && src2_reg[XLEN-1];
    assign mag1          = src1_neg ? (~src1_reg + 1'b1) : src1_reg;
    assign mag2          = src2_neg ? (~src2_reg + 1'b1) : src2_reg;

    // Restoring step: shift the next dividend bit into the partial remainder and try subtracting.
    assign shifted  = {rem_reg, quo_reg[XLEN-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_reg};
    assign ge       = !diff[XLEN+1];
    assign step_rem = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign step_quo = {quo_reg[XLEN-2:0], ge};

    // Final sign fix-up; divide by zero bypasses the iteration result entirely.
    always_comb begin
        q_fix = (src1_neg ^ src2_neg) ? (~quo_reg + 1'b1) : quo_reg;
        r_fix = src1_neg ? (~rem_reg + 1'b1) : rem_reg;
        if (src2_reg == '0) begin
            q_fix = '1;
            r_fix = src1_reg;
        end
        div_final = is_rem_op ? r_fix : q_fix;
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= D_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Divider next-state: start once a divide sits in the stage, hold DONE until hand-off.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            D_IDLE: if (valid_reg && is_div_op) state_next = D_BUSY;
            D_BUSY: if (cnt_reg == '0) state_next = D_SIGN;
            D_SIGN: state_next = D_DONE;
            D_DONE: if (out_allow) state_next = D_IDLE;
            default: state_next = D_IDLE;
        endcase
        if (flush) begin
            state_next = D_IDLE;
        end
    end

    // Divider datapath: load magnitudes, iterate XLEN steps, latch the signed result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            rem_reg <= '0;
            quo_reg <= '0;
            dvs_reg <= '0;
            res_reg <= '0;
        end else if (flush) begin
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                D_IDLE: begin
                    if (valid_reg && is_div_op) begin
                        rem_reg <= '0;
                        quo_reg <= mag1;
                        dvs_reg <= mag2;
                        cnt_reg <= CNT_W'(XLEN-1);
                    end
                end
                D_BUSY: begin
                    rem_reg <= step_rem;
                    quo_reg <= step_quo;
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                end
                D_SIGN: res_reg <= div_final;
                default: ;
            endcase
        end
    end

    assign ready_go   = is_div_op ? (state_reg == D_DONE) : 1'b1;
    assign div_result = res_reg;
`else
    assign ready_go   = 1'b1;
    assign div_result = '0;
`endif

    // Handshake and pass-through outputs; everything reads zero while the stage is empty.
    assign in_allow    = !valid_reg || (ready_go && out_allow);
    assign out_valid   = valid_reg && ready_go && !flush;
    assign out_pc      = valid_reg ? pc_reg : '0;
    assign out_result  = valid_reg ? alu_result : '0;
    assign out_dest    = valid_reg ? dest_reg : '0;
    assign out_gr_we   = valid_reg && gr_we_reg;
    assign out_mem_rd  = valid_reg && mem_rd_reg;
    assign out_ld_info = valid_reg ? {ld_signed_reg, size_reg, alu_result[OFF_W-1:0]} : '0;
    assign dsram_en    = valid_reg && (mem_rd_reg || mem_wr_reg);
    assign dsram_addr  = out_result;
    assign fwd_dest    = (valid_reg && gr_we_reg) ? dest_reg : '0;
    assign fwd_result  = out_result;
    assign fwd_is_load = valid_reg && mem_rd_reg;

    // Store lanes: the strobe covers [off, off+bytes); data repeats the store-sized chunk in every lane.
    logic       store_en;
    logic [4:0] off_ext, nbytes;

    assign store_en = valid_reg && mem_wr_reg && !flush;
    assign off_ext  = 5'(alu_result[OFF_W-1:0]);
    assign nbytes   = (size_reg == 2'd0) ? 5'd1 : (size_reg == 2'd1) ? 5'd2 : (size_reg == 2'd2) ? 5'd4 : 5'd8;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign dsram_we[gi] = store_en && (5'(gi) >= off_ext) && (5'(gi) < off_ext + nbytes);
            assign dsram_wdata[8*gi +: 8] =
                (size_reg == 2'd0) ? rkd_reg[7:0] :
                (size_reg == 2'd1) ? rkd_reg[8*(gi%2) +: 8] :
                (size_reg == 2'd2) ? rkd_reg[8*(gi%4) +: 8] :
                                     rkd_reg[8*(gi%8) +: 8];
        end
    endgenerate
endmodule

// File: tb/tb_ex_stage_mc.sv
// Testbench for ex_stage_mc (XLEN=32): compares against a behavioural arithmetic model.
// Divider scenarios are exercised when EX_STAGE_DIV_EN is defined.
// Without that macro, the divide ops are expected to return 0 in a single cycle.
module tb_ex_stage_mc;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_allow;
    logic [4:0]  in_op;
    logic [31:0] in_pc, in_src1, in_src2, in_rkd;
    logic [4:0]  in_dest;
    logic        in_gr_we, in_mem_rd, in_mem_wr;
    logic [1:0]  in_mem_size;
    logic        in_ld_signed;
    logic        out_valid, out_allow;
    logic [31:0] out_pc, out_result;
    logic [4:0]  out_dest;
    logic        out_gr_we, out_mem_rd;
    logic [4:0]  out_ld_info;
    logic        dsram_en;
    logic [3:0]  dsram_we;
    logic [31:0] dsram_addr, dsram_wdata;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_result;
    logic        fwd_is_load;

    int tests_run = 0;
    int tests_failed = 0;

    ex_stage_mc #(.XLEN(32), .DEST_W(5), .OP_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allow(in_allow), .in_op(in_op),
        .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_rkd(in_rkd),
        .in_dest(in_dest), .in_gr_we(in_gr_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_mem_size(in_mem_size), .in_ld_signed(in_ld_signed),
        .out_valid(out_valid), .out_allow(out_allow), .out_pc(out_pc), .out_result(out_result),
        .out_dest(out_dest), .out_gr_we(out_gr_we), .out_mem_rd(out_mem_rd), .out_ld_info(out_ld_info),
        .dsram_en(dsram_en), .dsram_we(dsram_we), .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata),
        .fwd_dest(fwd_dest), .fwd_result(fwd_result), .fwd_is_load(fwd_is_load)
    );

    always #5 clk = ~clk;

    // Reference model: result of one instruction from plain integer arithmetic.
    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = sa * sb;
        pu = ua * ub;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (ua < ub) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return a | b;
            6:  return a ^ b;
            7:  return ~(a | b);
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return 32'(sa >>> b[4:0]);
            11: return b;
            12: return p[31:0];
            13: return p[63:32];
            14: return pu[63:32];
`ifdef EX_STAGE_DIV_EN
            15: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            16: return (b == 0) ? a : 32'(sa % sb);
            17: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            18: return (b == 0) ? a : 32'(ua % ub);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Presents one instruction for exactly one capture edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rkd, input logic [4:0] dest, input logic gr_we,
                         input logic mrd, input logic mwr, input logic [1:0] size, input logic lds);
        in_op = op; in_src1 = a; in_src2 = b; in_rkd = rkd; in_dest = dest;
        in_gr_we = gr_we; in_mem_rd = mrd; in_mem_wr = mwr; in_mem_size = size;
        in_ld_signed = lds; in_pc = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        tests_run++;
        if (out_valid !== 1'b0 || in_allow !== 1'b1 || dsram_we !== 4'd0 || dsram_en !== 1'b0 ||
            fwd_dest !== 5'd0 || out_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b in_allow=%b we=%h en=%b fwd_dest=%0d result=%h required 0 1 0 0 0 0",
                     out_valid, in_allow, dsram_we, dsram_en, fwd_dest, out_result);
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_add;
        issue(5'd0, 32'd5, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'd12 || fwd_dest !== 5'd9 || fwd_result !== 32'd12) begin
            tests_failed++;
            $display("FAIL add_basic: valid=%b result=%h fwd_dest=%0d required 1 0000000c 9", out_valid, out_result, fwd_dest);
        end
        @(posedge clk); #2;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_drain: out_valid=%b required 0", out_valid);
        end
        $display("[TB] ADD 5+7 -> %h", out_result);
    endtask

    task automatic test_alu_random;
        for (int k = 0; k < 40; k++) begin
            logic [4:0]  op;
            logic [31:0] a, b, exp;
            logic [4:0]  d;
            op = 5'($urandom_range(0, 14));
            a  = (k % 4 == 0) ? 32'h8000_0000 : $urandom;
            b  = (k % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            d  = 5'($urandom_range(1, 31));
            exp = model(int'(op), a, b);
            issue(op, a, b, 32'd0, d, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== exp || fwd_dest !== d) begin
                tests_failed++;
                $display("FAIL alu_op%0d: a=%h b=%h got %h valid=%b dest=%0d required %h 1 %0d",
                         op, a, b, out_result, out_valid, fwd_dest, exp, d);
            end
            $display("[TB] alu op=%0d a=%h b=%h result=%h", op, a, b, out_result);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        for (int k = 0; k < 20; k++) begin
            in_op = 5'($urandom_range(0, 14)); in_src1 = $urandom; in_src2 = $urandom;
            in_dest = 5'(k + 1); in_gr_we = 1'b1; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
            in_valid = 1'b1;
            exp = model(int'(in_op), in_src1, in_src2);
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== exp || in_allow !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_%0d: result=%h valid=%b allow=%b required %h 1 1", k, out_result, out_valid, in_allow, exp);
            end
            $display("[TB] b2b op=%0d result=%h", in_op, out_result);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_store;
        issue(5'd0, 32'h1000, 32'd3, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        tests_run++;
        if (dsram_we !== 4'b1000 || dsram_wdata !== 32'hABAB_ABAB || dsram_en !== 1'b1 || dsram_addr !== 32'h1003 || fwd_dest !== 5'd0) begin
            tests_failed++;
            $display("FAIL store_byte: we=%b wdata=%h en=%b addr=%h fwd=%0d required 1000 abababab 1 1003 0",
                     dsram_we, dsram_wdata, dsram_en, dsram_addr, fwd_dest);
        end
        @(posedge clk); #1;
        issue(5'd0, 32'h1000, 32'd2, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        tests_run++;
        if (dsram_we !== 4'b1100 || dsram_wdata !== 32'h1234_1234) begin
            tests_failed++;
            $display("FAIL store_half: we=%b wdata=%h required 1100 12341234", dsram_we, dsram_wdata);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            logic [31:0] addr, data, exp_wd;
            logic [1:0]  sz;
            logic [3:0]  exp_we;
            int          nb, off;
            addr = $urandom; data = $urandom; sz = 2'($urandom_range(0, 3));
            nb = 1 << sz; off = int'(addr[1:0]);
            for (int i = 0; i < 4; i++) begin
                exp_we[i] = (i >= off) && (i < off + nb);
                exp_wd[8*i +: 8] = data[8*(i % nb) +: 8];
            end
            issue(5'd0, addr, 32'd0, data, 5'd0, 1'b0, 1'b0, 1'b1, sz, 1'b0);
            tests_run++;
            if (dsram_we !== exp_we || dsram_wdata !== exp_wd) begin
                tests_failed++;
                $display("FAIL store_rand: addr=%h size=%0d we=%b wdata=%h required %b %h", addr, sz, dsram_we, dsram_wdata, exp_we, exp_wd);
            end
            $display("[TB] store addr=%h size=%0d we=%b wdata=%h", addr, sz, dsram_we, dsram_wdata);
            @(posedge clk); #1;
        end
        // Load: forwarding flag and load info.
        issue(5'd0, 32'h2000, 32'd6, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        tests_run++;
        if (fwd_is_load !== 1'b1 || out_ld_info !== 5'b1_01_10 || dsram_we !== 4'd0 || dsram_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_info: is_load=%b ld_info=%b we=%b en=%b required 1 10110 0000 1", fwd_is_load, out_ld_info, dsram_we, dsram_en);
        end
        @(posedge clk); #1;
        // Store stalled by the memory stage, then flushed: strobes drop in the flush cycle.
        out_allow = 1'b0;
        issue(5'd0, 32'h3000, 32'd0, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (dsram_we !== 4'b0001 || in_allow !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_stall: we=%b in_allow=%b required 0001 0", dsram_we, in_allow);
        end
        flush = 1'b1; #1;
        tests_run++;
        if (dsram_we !== 4'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_flush: we=%b out_valid=%b required 0000 0", dsram_we, out_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0; out_allow = 1'b1; #1;
        tests_run++;
        if (dsram_en !== 1'b0 || in_allow !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_after_flush: en=%b in_allow=%b required 0 1", dsram_en, in_allow);
        end
        $display("[TB] store flush checked");
    endtask

`ifdef EX_STAGE_DIV_EN
    // Runs one divide with out_allow high; reports cycles from capture to out_valid.
    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output int bad_allow);
        lat = 0; res = 32'd0; bad_allow = 0;
        issue(op, a, b, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) #1;
            @(posedge clk); #2;
            if (out_valid === 1'b1) begin
                lat = k;
                res = out_result;
                break;
            end
            if (in_allow !== 1'b0) bad_allow++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div;
        logic [4:0]  ops [8]  = '{5'd15, 5'd16, 5'd17, 5'd18, 5'd15, 5'd16, 5'd15, 5'd16};
        logic [31:0] as  [8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] bs  [8]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        int lat, bad;
        logic [31:0] res, exp, a, b;
        logic [4:0]  op;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) begin
                op = ops[k]; a = as[k]; b = bs[k];
            end else begin
                op = 5'($urandom_range(15, 18)); a = $urandom;
                b = (k % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
                if (k % 2 == 0) a = {a[31], 31'($urandom_range(0, 100000))};
            end
            exp = model(int'(op), a, b);
            run_div(op, a, b, lat, res, bad);
            tests_run++;
            if (lat != XLEN + 2 || res !== exp || bad != 0) begin
                tests_failed++;
                $display("FAIL div_op%0d: a=%h b=%h got %h latency %0d allow_high %0d required %h %0d 0",
                         op, a, b, res, lat, bad, exp, XLEN + 2);
            end
            $display("[TB] div op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, res, lat);
        end
    endtask

    task automatic test_flush;
        int seen;
        issue(5'd15, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1; #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_busy_valid: out_valid=%b required 0", out_valid);
        end
        @(posedge clk); #1;
        flush = 1'b0; #1;
        tests_run++;
        if (in_allow !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_allow: in_allow=%b required 1", in_allow);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL flush_no_result: out_valid cycles=%0d required 0", seen);
        end
        issue(5'd0, 32'd3, 32'd4, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'd7) begin
            tests_failed++;
            $display("FAIL flush_next_add: valid=%b result=%h required 1 00000007", out_valid, out_result);
        end
        @(posedge clk); #1;
        $display("[TB] flush during divide checked");
    endtask

    task automatic test_stall;
        int lat, bad, unstable;
        logic [31:0] res;
        out_allow = 1'b0;
        issue(5'd17, 32'd100, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat != XLEN + 2) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d required %0d", lat, XLEN + 2);
        end
        unstable = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_result !== 32'd14 || in_allow !== 1'b0) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: unstable cycles=%0d result=%h required 0 0000000e", unstable, out_result);
        end
        in_op = 5'd1; in_src1 = 32'd50; in_src2 = 32'd8; in_dest = 5'd2; in_gr_we = 1'b1;
        in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_valid = 1'b1; out_allow = 1'b1; #1;
        tests_run++;
        if (in_allow !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_handoff_allow: in_allow=%b required 1", in_allow);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'd42) begin
            tests_failed++;
            $display("FAIL stall_next_op: valid=%b result=%h required 1 0000002a", out_valid, out_result);
        end
        @(posedge clk); #1;
        run_div(5'd16, 32'hFFFF_FFF9, 32'd2, lat, res, bad);
        tests_run++;
        if (lat != XLEN + 2 || res !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL stall_redo_div: result=%h latency=%0d required ffffffff %0d", res, lat, XLEN + 2);
        end
        $display("[TB] divider stall and hand-off checked");
    endtask
`else
    task automatic test_div;
        for (int op = 15; op <= 18; op++) begin
            issue(5'(op), $urandom, 32'd3, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== 32'd0) begin
                tests_failed++;
                $display("FAIL div_disabled_op%0d: valid=%b result=%h required 1 00000000", op, out_valid, out_result);
            end
            $display("[TB] div op=%0d (disabled) result=%h", op, out_result);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allow = 1'b1;
        in_op = 5'd0; in_pc = 32'd0; in_src1 = 32'd0; in_src2 = 32'd0; in_rkd = 32'd0;
        in_dest = 5'd0; in_gr_we = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
        in_mem_size = 2'd0; in_ld_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        test_reset();
        test_add();
        test_alu_random();
        test_back_to_back();
        test_store();
        test_div();
`ifdef EX_STAGE_DIV_EN
        test_flush();
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
